// File: rtl/oets_sort_ctrl_if.sv
// Stream bundle for the odd-even transposition sort lane: one valid/ready
// input stream of words and one valid/ready output stream of sorted words.
interface oets_sort_ctrl_if #(
    parameter int unsigned W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;

    // Producer/consumer side (drives input words, accepts sorted words)
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    // Sort controller side
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/oets_sort_ctrl.sv
// Odd-even transposition sort controller for a single sort lane.
// LOAD collects N words, SORT runs one compare-exchange phase per cycle
// (even phases pair (0,1),(2,3)..., odd phases pair (1,2),(3,4)...),
// DRAIN streams the row out smallest first.
// Optional feature: define OETS_EARLY_EXIT_EN to end SORT once two
// consecutive phases perform no swap (minimum 2 phases, maximum N).
module oets_sort_ctrl #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 32
) (
    input  logic              clk,
    input  logic              rst,
    oets_sort_ctrl_if.slave   bus,
    output logic              busy,
    output logic [$clog2(N):0] phases_used
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned PW = IW + 1;
    localparam logic [IW-1:0] LAST_IDX   = IW'(N - 1);
    localparam logic [PW-1:0] LAST_PHASE = PW'(N - 1);

    typedef enum logic [1:0] {
        LOAD,
        SORT,
        DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  row_q [N];
    logic [W-1:0]  row_d [N];
    logic [W-1:0]  xchg  [N];
    logic [IW-1:0] wr_idx_q, wr_idx_d;
    logic [IW-1:0] rd_idx_q, rd_idx_d;
    logic [PW-1:0] p_q, p_d;
    logic [PW-1:0] phases_q, phases_d;
    logic          in_rdy, out_vld;
    logic          in_fire, out_fire;
    logic          sort_done;
`ifdef OETS_EARLY_EXIT_EN
    logic          any_swap;
    logic          quiet_q, quiet_d;
`endif

    assign in_rdy   = (state_q == LOAD);
    assign out_vld  = (state_q == DRAIN);
    assign in_fire  = bus.in_valid & in_rdy;
    assign out_fire = out_vld & bus.out_ready;

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld;
    assign bus.out_data  = out_vld ? row_q[rd_idx_q] : '0;
    assign bus.out_last  = out_vld && (rd_idx_q == LAST_IDX);
    assign busy          = (state_q == SORT) || (state_q == DRAIN);
    assign phases_used   = phases_q;

    // One compare-exchange phase over the row; pairs are disjoint so all swap at once
    always_comb begin
        xchg = row_q;
`ifdef OETS_EARLY_EXIT_EN
        any_swap = 1'b0;
`endif
        for (int unsigned i = 0; i + 1 < N; i++) begin
            if ((i[0] == p_q[0]) && (row_q[i] > row_q[i+1])) begin
                xchg[i]   = row_q[i+1];
                xchg[i+1] = row_q[i];
`ifdef OETS_EARLY_EXIT_EN
                any_swap  = 1'b1;
`endif
            end
        end
    end

    // Next-state and datapath update for LOAD/SORT/DRAIN
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        wr_idx_d  = wr_idx_q;
        rd_idx_d  = rd_idx_q;
        p_d       = p_q;
        phases_d  = phases_q;
        sort_done = 1'b0;
`ifdef OETS_EARLY_EXIT_EN
        quiet_d   = quiet_q;
`endif
        case (state_q)
            LOAD: begin
                if (in_fire) begin
                    row_d[wr_idx_q] = bus.in_data;
                    if (wr_idx_q == LAST_IDX) begin
                        wr_idx_d = '0;
                        p_d      = '0;
                        state_d  = SORT;
`ifdef OETS_EARLY_EXIT_EN
                        quiet_d  = 1'b0;
`endif
                    end else begin
                        wr_idx_d = wr_idx_q + 1'b1;
                    end
                end
            end
            SORT: begin
                row_d     = xchg;
                p_d       = p_q + 1'b1;
                sort_done = (p_q == LAST_PHASE);
`ifdef OETS_EARLY_EXIT_EN
                // quiet_q remembers that the previous phase swapped nothing
                quiet_d = ~any_swap;
                if ((p_q != '0) && !any_swap && quiet_q) begin
                    sort_done = 1'b1;
                end
`endif
                if (sort_done) begin
                    phases_d = p_q + 1'b1;
                    rd_idx_d = '0;
                    state_d  = DRAIN;
                end
            end
            DRAIN: begin
                if (out_fire) begin
                    if (rd_idx_q == LAST_IDX) begin
                        rd_idx_d = '0;
                        state_d  = LOAD;
                    end else begin
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= LOAD;
            for (int unsigned i = 0; i < N; i++) begin
                row_q[i] <= '0;
            end
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            p_q      <= '0;
            phases_q <= '0;
`ifdef OETS_EARLY_EXIT_EN
            quiet_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            p_q      <= p_d;
            phases_q <= phases_d;
`ifdef OETS_EARLY_EXIT_EN
            quiet_q  <= quiet_d;
`endif
        end
    end

endmodule

// File: doc/oets_sort_ctrl.md
# oets_sort_ctrl

Sequencing controller for the odd-even transposition sort datapath. It accepts N unsigned words over a valid/ready input stream and holds them in an internal register row. It then runs alternating even/odd compare-exchange phases across adjacent pairs, using the same swap-if-left-greater rule as the team's PE cell, and streams the sorted row out, smallest first, over a valid/ready output stream. It is the top-level control for a single sort lane.

## Interface
Parameters:
- N, 8, number of elements per sort batch; must be ≥2.
- W, 32, element width in bits; compare is unsigned.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  controller can accept a word.
- in_data  input  W  input word.
- out_valid  output  1  sorted word present.
- out_ready  input  1  downstream accepts a word.
- out_data  output  W  sorted word.
- out_last  output  1  marks the Nth (largest) output word.
- busy  output  1  high in SORT and DRAIN.
- phases_used  output  $clog2(N)+1  number of phases executed for the current batch; valid in DRAIN.

## Operation
- The FSM has three states: LOAD, SORT and DRAIN. Reset state is LOAD.
- **LOAD**
  - in_ready=1.
  - On in_valid&in_ready, write in_data to reg[wr_idx] and increment wr_idx.
  - On the accept where wr_idx==N-1: go to SORT, clear wr_idx, clear phase counter p.
- **SORT**
  - in_ready=0. One phase per cycle.
  - Even p: compare pairs (0,1),(2,3),…
  - Odd p: compare pairs (1,2),(3,4),…
  - Unpaired end elements hold.
  - Per pair: if reg[i] > reg[i+1] (unsigned), swap; otherwise hold. All pairs of a phase update simultaneously.
  - p increments each cycle. After phase N-1 completes (or early exit, see Configuration), go to DRAIN and latch phases_used.
- **DRAIN**
  - out_valid=1, out_data=reg[rd_idx], out_last=(rd_idx==N-1).
  - On out_valid&out_ready, increment rd_idx.
  - On the handshake with out_last=1: go to LOAD, clear rd_idx.
- Outputs are stable while out_valid=1 and out_ready=0.
- Equal elements never swap.
- Output is non-decreasing.

## Timing
- Reset values:
  - in_ready=1; out_valid=0; out_last=0; busy=0.
  - out_data=0; phases_used=0.
  - All reg[], wr_idx, rd_idx and p are 0.
- Assertion of rst clears state immediately, in any state, including mid-SORT and mid-DRAIN. The partial batch is discarded. The first cycle after deassertion is LOAD.
- If the last input is accepted in cycle t:
  - SORT occupies cycles t+1..t+K, where K = phases executed.
  - out_valid first asserts in cycle t+K+1.
  - With out_ready held at 1, the last word transfers in cycle t+K+N.
- in_ready returns to 1 in the cycle after the out_last handshake. There is no overlap of load and drain.
- Input gaps (in_valid=0) in LOAD simply stall. There is no timeout.
- in_valid asserted outside LOAD is ignored; the word is not consumed.
- No combinational path exists from in_valid to in_ready, or from out_ready to out_valid.

## Configuration
- **OETS_EARLY_EXIT_EN defined:**
  - Track whether any pair swapped in each phase.
  - If phase p (p≥1) and phase p-1 both had zero swaps, SORT ends after phase p, and phases_used=p+1.
  - The minimum is 2 phases; the maximum is N.
- **Not defined:**
  - Always exactly N phases; phases_used=N.
  - The swap-tracking logic is absent.

## Test plan
- Reverse order: N=8, load 8,7,…,1 → out 1,2,…,8; out_last only on 8; phases_used=8; first out_valid 9 cycles after the last input accept.
- Presorted input: load 1..8 → with macro, phases_used=2 and out_valid 3 cycles after the last accept; without macro, phases_used=8. Output 1..8 in both cases.
- Duplicates and unsigned extremes: load 0xFFFFFFFF,0,5,5,0x80000000,1,0,5 → out 0,0,1,5,5,5,0x80000000,0xFFFFFFFF.
- Backpressure and gaps:
  - Insert random in_valid gaps and out_ready toggling (e.g. 1,0,0,1,…); data must match a golden sort.
  - out_data must hold while stalled.
  - in_ready=0 throughout SORT and DRAIN.
- Reset mid-operation:
  - Assert rst during SORT phase 3 → all outputs return to reset values in the same cycle.
  - A fresh batch of 3,1,2,… then sorts correctly, with no stale words.
- Back-to-back batches: two batches with out_ready=1 and in_valid=1 held → the second batch's first word is accepted the cycle after the first batch's out_last handshake, and both batches sort correctly.
